// File: rtl/pe_pkg.sv
// Shared PE definitions: accumulator FSM states and default widths.
// Imported by the partial-sum accumulator and its neighbours.
package pe_pkg;

  localparam int PROD_WIDTH = 32;
  localparam int PSUM_WIDTH = 32;
  localparam int CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    WAIT_PSUM,
    OUT
  } state_e;

endpackage

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator behind the PE multiplier.
// Ports:
//   clk, reset (async, active-high)
//   cfg_len, cfg_use_psum_in : per-psum configuration
//   prod_in/prod_valid       : products from the multiplier
//   psum_in/_valid/_ready    : neighbour psum input handshake
//   psum_out/_valid/_ready   : result output handshake
//   mul_den                  : hold request to the multiplier
//   busy                     : FSM not idle
module psum_accumulator #(
  parameter int PROD_WIDTH = pe_pkg::PROD_WIDTH,
  parameter int PSUM_WIDTH = pe_pkg::PSUM_WIDTH,
  parameter int CNT_WIDTH  = pe_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_WIDTH-1:0]  cfg_len,
  input  logic                  cfg_use_psum_in,
  input  logic [PROD_WIDTH-1:0] prod_in,
  input  logic                  prod_valid,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  psum_in_valid,
  output logic                  psum_in_ready,
  output logic [PSUM_WIDTH-1:0] psum_out,
  output logic                  psum_out_valid,
  input  logic                  psum_out_ready,
  output logic                  mul_den,
  output logic                  busy
);
  import pe_pkg::*;

  state_e                state_q;
  logic [PSUM_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic                  use_q;

  logic [PSUM_WIDTH-1:0] prod_ext;
  logic [CNT_WIDTH-1:0]  len_d;
  logic [CNT_WIDTH-1:0]  cnt_inc;

  // Size cast zero-extends or drops upper product bits as needed.
  assign prod_ext = PSUM_WIDTH'(prod_in);
  assign len_d    = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
  assign cnt_inc  = cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      use_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (prod_valid) begin
            acc_q <= prod_ext;
            cnt_q <= CNT_WIDTH'(1);
            len_q <= len_d;
            use_q <= cfg_use_psum_in;
            if (len_d == CNT_WIDTH'(1))
              state_q <= cfg_use_psum_in ? WAIT_PSUM : OUT;
            else
              state_q <= ACC;
          end
        end
        ACC: begin
          if (prod_valid) begin
            acc_q <= acc_q + prod_ext;
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q)
              state_q <= use_q ? WAIT_PSUM : OUT;
          end
        end
        WAIT_PSUM: begin
          if (psum_in_valid) begin
            acc_q   <= acc_q + psum_in;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (psum_out_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly, so mul_den rises in
  // the same cycle WAIT_PSUM/OUT is entered.
  assign psum_in_ready  = (state_q == WAIT_PSUM);
  assign psum_out_valid = (state_q == OUT);
  assign psum_out       = acc_q;
  assign mul_den        = (state_q == WAIT_PSUM) || (state_q == OUT);
  assign busy           = (state_q != IDLE);

endmodule
